synapse_obi_loader: RTL and testbench
=====================================

// Module: synapse_obi_loader
// PURPOSE
//  OBI initiator that bulk-programs the synaptic SRAM through the synaptic core's OBI responder port.
//  Per word: reads a 32-bit weight word from system memory, then writes it to the synapse array.
//  Sits between the tinyODIN config registers and the bus crossbar; replaces per-word CPU stores.
//  Single port, one outstanding transaction, strictly alternating read/write.
// PARAMETERS
//  SYN_AW      13        synapse word-address width (8192 x 32 array)
//  LEN_W       14        transfer-length width (0..8192 words)
//  DST_PREFIX  32'h0     upper address bits [31:SYN_AW] driven on writes
//  req_t       logic     OBI request struct (req, we, be, addr, wdata)
//  rsp_t       logic     OBI response struct (gnt, rvalid, rdata)
// PORTS
//  CLK            in   1       clock, all logic on posedge
//  RST            in   1       synchronous reset, active-high
//  start_i        in   1       one-cycle start pulse; sampled only in IDLE
//  abort_i        in   1       stop after the current bus transaction completes
//  src_addr_i     in   32      source byte address (word aligned), latched at start
//  dst_idx_i      in   SYN_AW  first synapse word index, latched at start
//  len_i          in   LEN_W   number of words, latched at start
//  busy_o         out  1       high from accepted start until return to IDLE
//  done_o         out  1       one-cycle pulse on normal completion (not on abort)
//  words_done_o   out  LEN_W   count of words fully written in current/last transfer
//  master_req_o   out  req_t   OBI request to crossbar / synaptic core
//  master_rsp_i   in   rsp_t   OBI response
// BEHAVIOUR
//  Reset (sync, RST=1): state IDLE; req=0, we=0, be=4'hF, addr=0, wdata=0; busy_o=0, done_o=0, words_done_o=0.
//  FSM: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
//   IDLE:    start_i & len_i!=0 -> RD_REQ, latch args, clear words_done_o; start_i & len_i==0 -> DONE.
//   RD_REQ:  req=1, we=0, addr=src_cur; gnt -> RD_WAIT.
//   RD_WAIT: req=0; rvalid -> capture rdata into data_q, -> WR_REQ.
//   WR_REQ:  req=1, we=1, addr={DST_PREFIX[31:SYN_AW], dst_cur}, wdata=data_q; gnt -> WR_WAIT.
//   WR_WAIT: req=0; rvalid -> words_done_o+1, src_cur+4, dst_cur+1;
//            last word -> DONE; abort seen -> IDLE; else -> RD_REQ.
//   DONE:    done_o=1 for exactly one cycle -> IDLE.
//  OBI rules:
//   - addr/we/wdata held stable while req=1 and gnt=0.
//   - req never deasserted before gnt.
//   - next req is issued only after the previous rvalid, so at most one transaction is outstanding.
//   - rvalid arrives >=1 cycle after gnt; rvalid in IDLE/RD_REQ/WR_REQ/DONE is ignored.
//  Throughput with gnt=req and rvalid one cycle later: 4 cycles/word; total = 4*len+1 cycles start->done_o.
//  Arithmetic:
//   - src_cur wraps modulo 2^32.
//   - dst_cur wraps modulo 2^SYN_AW (index 8191 -> 0).
//   - words_done_o saturates at len.
//  abort_i:
//   - sticky flag while busy; cleared when the FSM returns to IDLE.
//   - in RD_REQ/WR_REQ the pending req still completes its gnt/rvalid.
//   - after abort in the read phase, the fetched word is NOT written; return to IDLE from RD_WAIT rvalid.
//   - abort in the write phase: return to IDLE from WR_WAIT rvalid, counting that word.
//   - no done_o on abort.
//  start_i while busy: ignored, arguments not re-latched. Simultaneous start_i & abort_i in IDLE: start wins.
//  RST mid-transfer: req drops next edge; a late rvalid from the slave after reset is ignored (IDLE).
// STRUCTURE
//  tinyodin_pkg:
//   - loader_state_e enum.
//   - SYN_AW constant.
//   - obi req/rsp typedefs shared with the synaptic and neuron cores.
//  Single module; no sub-module. Datapath (src_cur, dst_cur, data_q, counters) plus one FSM process.
// TESTING
//  1. len=3, src=0x1000, dst=5, mem{0x1000:A,0x1004:B,0x1008:C}, zero-wait slave
//     -> syn[5..7]=A,B,C; done_o at cycle 13; words_done_o=3.
//  2. gnt delayed 0-3 random cycles, rvalid delayed 1-4 cycles
//     -> req/addr/wdata stable until gnt; never two outstanding; data correct.
//  3. len=0 -> done_o one cycle after start; no req ever asserted.
//  4. dst=8190, len=4 -> writes to indices 8190, 8191, 0, 1; src advances by 4 each word.
//  5. abort_i during RD_WAIT of word 2 (len=5)
//     -> word 2 not written; IDLE; done_o=0; words_done_o=1.
//  6. RST asserted in WR_REQ, then a stale rvalid from the slave
//     -> outputs at reset values; new start runs a correct transfer.

Source files
------------

// File: rtl/tinyodin_pkg.sv
// Shared tinyODIN definitions: synapse geometry, loader FSM states and the
// OBI request/response structs used by the synaptic and neuron cores.
package tinyodin_pkg;

    // Synapse array is 8192 x 32-bit words.
    localparam int SYN_AW = 13;

    // Every loader access is a full 32-bit word.
    localparam logic [3:0] OBI_BE_WORD = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } loader_state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/synapse_obi_loader.sv
// OBI initiator that copies a block of 32-bit weight words from system memory
// into the synapse array, one read followed by one write per word, with a
// single transaction outstanding at any time.
module synapse_obi_loader
    import tinyodin_pkg::*;
#(
    parameter int          SYN_AW     = tinyodin_pkg::SYN_AW,
    parameter int          LEN_W      = 14,
    parameter logic [31:0] DST_PREFIX = 32'h0,
    parameter type         req_t      = obi_req_t,
    parameter type         rsp_t      = obi_rsp_t
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [31:0]       src_addr_i,
    input  logic [SYN_AW-1:0] dst_idx_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  words_done_o,
    output req_t              master_req_o,
    input  rsp_t              master_rsp_i
);

    localparam logic [31:0] SRC_STEP = 32'd4;

    loader_state_e     state_q, state_d;
    logic [31:0]       src_q, src_d;     // byte address of the next word to read
    logic [SYN_AW-1:0] dst_q, dst_d;     // synapse index of the next word to write
    logic [31:0]       data_q, data_d;   // word fetched and waiting to be written
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;     // words fully written in this transfer
    logic              abort_q, abort_d; // abort requested while busy
    req_t              req_d;

    logic abort_seen;
    logic last_word;

    // A live abort counts in the same cycle it is raised, not only once it is sticky.
    assign abort_seen = abort_q | abort_i;
    // The word currently completing is the final one of the transfer.
    assign last_word  = (cnt_q + LEN_W'(1)) >= len_q;

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign words_done_o = cnt_q;
    assign master_req_o = req_d;

    // Next-state, datapath update and OBI request generation.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        abort_d = abort_q | (busy_o & abort_i);
        req_d    = '0;
        req_d.be = OBI_BE_WORD;

        case (state_q)
            IDLE: begin
                // Start beats a simultaneous abort: the flag is not armed from IDLE.
                abort_d = 1'b0;
                if (start_i) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_idx_i;
                    len_d   = len_i;
                    cnt_d   = '0;
                    state_d = (len_i != '0) ? RD_REQ : DONE;
                end
            end
            RD_REQ: begin
                req_d.req  = 1'b1;
                req_d.addr = src_q;
                if (master_rsp_i.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (master_rsp_i.rvalid) begin
                    data_d  = master_rsp_i.rdata;
                    // An abort during the read drops the fetched word.
                    state_d = abort_seen ? IDLE : WR_REQ;
                end
            end
            WR_REQ: begin
                req_d.req   = 1'b1;
                req_d.we    = 1'b1;
                req_d.addr  = {DST_PREFIX[31:SYN_AW], dst_q};
                req_d.wdata = data_q;
                if (master_rsp_i.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (master_rsp_i.rvalid) begin
                    if (cnt_q < len_q) cnt_d = cnt_q + LEN_W'(1);
                    src_d = src_q + SRC_STEP;
                    dst_d = dst_q + SYN_AW'(1);
                    if (last_word)       state_d = DONE;
                    else if (abort_seen) state_d = IDLE;
                    else                 state_d = RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make every register see pre-edge values.
        if (RST) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_synapse_obi_loader.sv
// Self-checking bench for synapse_obi_loader: an OBI slave with random
// grant/response latency, a source memory defined by a hash function, and a
// reference synapse array updated from the transfer rules.
module tb_synapse_obi_loader;
    import tinyodin_pkg::*;

    localparam int          AW     = 13;
    localparam int          LW     = 14;
    localparam int          NSYN   = 8192;
    localparam logic [31:0] PREFIX = 32'h4000_0000;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [31:0]   src_addr_i = '0;
    logic [AW-1:0] dst_idx_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [LW-1:0] words_done_o;
    obi_req_t      master_req;
    obi_rsp_t      master_rsp;

    synapse_obi_loader #(
        .SYN_AW(AW), .LEN_W(LW), .DST_PREFIX(PREFIX),
        .req_t(obi_req_t), .rsp_t(obi_rsp_t)
    ) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .abort_i(abort_i),
        .src_addr_i(src_addr_i), .dst_idx_i(dst_idx_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .words_done_o(words_done_o),
        .master_req_o(master_req), .master_rsp_i(master_rsp)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Source memory contents as a pure function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- OBI slave ----------------
    bit          slave_en  = 1'b1;
    bit          zero_wait = 1'b1;
    bit          hold_wr   = 1'b0;
    logic        slv_gnt = 1'b0, slv_rvalid = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic        stale_rvalid = 1'b0;
    logic [31:0] stale_rdata = '0;

    assign master_rsp.gnt    = slv_gnt;
    assign master_rsp.rvalid = slv_rvalid | stale_rvalid;
    assign master_rsp.rdata  = stale_rvalid ? stale_rdata : slv_rdata;

    logic [31:0] syn_mem [NSYN];
    logic [31:0] syn_ref [NSYN];
    logic [31:0] rd_q [$];
    logic [31:0] wr_q [$];

    int          gnt_wait = -1;
    int          rv_left = 0;
    bit          hs = 1'b0, outstanding = 1'b0, waiting = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata, rd_pending;

    // Slave drives gnt/rvalid on the falling edge so the DUT samples them cleanly.
    always @(negedge CLK) begin
        if (!slave_en || RST) begin
            slv_gnt = 1'b0; slv_rvalid = 1'b0; hs = 1'b0; outstanding = 1'b0;
            waiting = 1'b0; gnt_wait = -1; rv_left = 0;
        end else begin
            if (slv_rvalid) begin
                slv_rvalid = 1'b0;
                outstanding = 1'b0;
            end
            if (hs) begin
                hs = 1'b0; slv_gnt = 1'b0; outstanding = 1'b1;
                rv_left = zero_wait ? 1 : int'($urandom_range(4, 1));
                if (p_we) begin
                    wr_q.push_back(p_addr);
                    syn_mem[p_addr[AW-1:0]] = p_wdata;
                    rd_pending = $urandom;
                end else begin
                    rd_q.push_back(p_addr);
                    rd_pending = mem_word(p_addr);
                end
            end
            if (outstanding && !slv_rvalid && rv_left > 0) begin
                if (rv_left == 1) begin
                    slv_rvalid = 1'b1;
                    slv_rdata  = rd_pending;
                end
                rv_left--;
            end
            check("one_outstanding", 96'(master_req.req & outstanding), 96'(0));
            if (waiting)
                check("req_stable", 96'({master_req.req, master_req.we, master_req.addr, master_req.wdata}),
                      96'({1'b1, p_we, p_addr, p_wdata}));
            waiting = 1'b0;
            if (master_req.req && !outstanding) begin
                if (gnt_wait < 0) begin
                    gnt_wait = zero_wait ? 0 : int'($urandom_range(3, 0));
                    p_we = master_req.we; p_addr = master_req.addr; p_wdata = master_req.wdata;
                end
                if (hold_wr && master_req.we) begin
                    waiting = 1'b1;
                end else if (gnt_wait == 0) begin
                    slv_gnt = 1'b1; hs = 1'b1; gnt_wait = -1;
                end else begin
                    gnt_wait--;
                    waiting = 1'b1;
                end
            end
        end
    end

    obi_req_t idle_req;
    initial idle_req = '{req: 1'b0, we: 1'b0, be: 4'hF, addr: 32'h0, wdata: 32'h0};

    // ---------------- transfer driver + reference model ----------------
    // amode: 0 = no abort, 1 = abort while read of word ak is outstanding,
    //        2 = abort while write of word ak is outstanding.
    task automatic run_xfer(input string tag, input logic [31:0] src, input logic [AW-1:0] dst,
                            input logic [LW-1:0] len, input int amode, input int ak,
                            input bit poke_start, input bit abort_with_start);
        int rd0, wr0, cyc, done_cnt, done_at, n, n_rd, idx;
        bit fired;
        logic [31:0] a;
        logic [31:0] pfx;
        rd0 = rd_q.size(); wr0 = wr_q.size();
        fired = 1'b0; done_cnt = 0; done_at = 0;
        @(negedge CLK); #1;
        start_i = 1'b1; src_addr_i = src; dst_idx_i = dst; len_i = len;
        abort_i = abort_with_start;
        @(posedge CLK); #1;
        start_i = 1'b0; cyc = 1;
        if (done_o) begin done_cnt++; done_at = cyc; end
        while (busy_o && cyc < 400) begin
            @(negedge CLK); #1;
            abort_i = 1'b0; start_i = 1'b0;
            if (!fired && amode == 1 && rd_q.size() - rd0 == ak + 1) begin abort_i = 1'b1; fired = 1'b1; end
            if (!fired && amode == 2 && wr_q.size() - wr0 == ak + 1) begin abort_i = 1'b1; fired = 1'b1; end
            if (poke_start && cyc == 6) begin
                start_i = 1'b1; src_addr_i = $urandom; dst_idx_i = AW'($urandom); len_i = LW'($urandom);
            end
            @(posedge CLK); #1;
            cyc++;
            if (done_o) begin done_cnt++; done_at = cyc; end
        end
        abort_i = 1'b0; start_i = 1'b0;

        n = int'(len); n_rd = int'(len);
        if (amode != 0) begin n_rd = ak + 1; n = (amode == 1) ? ak : ak + 1; end

        check({tag, "/finished"}, 96'(busy_o), 96'(0));
        check({tag, "/req_idle"}, 96'(master_req), 96'(idle_req));
        check({tag, "/words_done"}, 96'(words_done_o), 96'(n));
        check({tag, "/done_pulses"}, 96'(done_cnt), 96'((amode == 0) ? 1 : 0));
        if (zero_wait && amode == 0)
            check({tag, "/latency"}, 96'(done_at), 96'(4 * int'(len) + 1));
        check({tag, "/rd_count"}, 96'(rd_q.size() - rd0), 96'(n_rd));
        for (int i = 0; i < n_rd && rd0 + i < rd_q.size(); i++) begin
            a = src + 32'(4 * i);
            check({tag, "/rd_addr"}, 96'(rd_q[rd0 + i]), 96'(a));
        end
        check({tag, "/wr_count"}, 96'(wr_q.size() - wr0), 96'(n));
        pfx = PREFIX;
        for (int i = 0; i < n; i++) begin
            idx = (int'(dst) + i) % NSYN;
            if (wr0 + i < wr_q.size())
                check({tag, "/wr_addr"}, 96'(wr_q[wr0 + i]), 96'({pfx[31:AW], AW'(idx)}));
            syn_ref[idx] = mem_word(src + 32'(4 * i));
        end
        for (int i = 0; i < int'(len); i++) begin
            idx = (int'(dst) + i) % NSYN;
            check({tag, "/syn"}, 96'(syn_mem[idx]), 96'(syn_ref[idx]));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check("rst/req", 96'(master_req), 96'(idle_req));
        check("rst/busy", 96'(busy_o), 96'(0));
        check("rst/done", 96'(done_o), 96'(0));
        check("rst/words", 96'(words_done_o), 96'(0));
        RST = 1'b0;

        // Directed, zero-wait slave.
        zero_wait = 1'b1;
        run_xfer("t1_basic", 32'h0000_1000, AW'(5), LW'(3), 0, 0, 1'b0, 1'b0);
        run_xfer("t3_len0", 32'h0000_2000, AW'(9), LW'(0), 0, 0, 1'b0, 1'b0);
        run_xfer("t4_wrap", 32'h0000_3000, AW'(8190), LW'(4), 0, 0, 1'b1, 1'b0);
        run_xfer("t5_abort_rd", 32'h0000_4000, AW'(20), LW'(5), 1, 1, 1'b0, 1'b0);
        run_xfer("abort_wr", 32'h0000_5000, AW'(40), LW'(5), 2, 2, 1'b0, 1'b0);
        run_xfer("start_wins", 32'hFFFF_FFF8, AW'(60), LW'(3), 0, 0, 1'b0, 1'b1);

        // Randomised grant/response latency with random aborts and ignored starts.
        zero_wait = 1'b0;
        for (int t = 0; t < 16; t++) begin
            logic [31:0]   r_src;
            logic [AW-1:0] r_dst;
            logic [LW-1:0] r_len;
            int am, ak;
            r_src = $urandom;
            r_src[1:0] = 2'b00;
            if (t % 5 == 0) r_src = 32'hFFFF_FFF0;
            r_dst = AW'($urandom);
            r_len = LW'($urandom_range(12, 1));
            am = int'($urandom_range(2, 0));
            if (am == 2 && r_len < 2) am = 0;
            ak = 0;
            if (am == 1) ak = int'($urandom_range(int'(r_len) - 1, 0));
            if (am == 2) ak = int'($urandom_range(int'(r_len) - 2, 0));
            run_xfer("t2_rand", r_src, r_dst, r_len, am, ak, t[0], (am == 0) && t[1]);
        end

        // Reset while a write request is pending, then a stale rvalid.
        zero_wait = 1'b1;
        hold_wr = 1'b1;
        @(negedge CLK); #1;
        start_i = 1'b1; src_addr_i = 32'h0000_6000; dst_idx_i = AW'(100); len_i = LW'(3);
        @(posedge CLK); #1;
        start_i = 1'b0; cyc = 0;
        while (!(master_req.req && master_req.we) && cyc < 50) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("t6/in_wr_req", 96'(master_req.req & master_req.we), 96'(1));
        slave_en = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        check("t6/rst_req", 96'(master_req), 96'(idle_req));
        check("t6/rst_busy", 96'(busy_o), 96'(0));
        check("t6/rst_words", 96'(words_done_o), 96'(0));
        RST = 1'b0;
        @(negedge CLK); #1;
        stale_rdata = $urandom;
        stale_rvalid = 1'b1;
        @(posedge CLK); #1;
        check("t6/stale_busy", 96'(busy_o), 96'(0));
        check("t6/stale_req", 96'(master_req), 96'(idle_req));
        check("t6/stale_done", 96'(done_o), 96'(0));
        stale_rvalid = 1'b0;
        hold_wr = 1'b0;
        slave_en = 1'b1;
        run_xfer("t6_after", 32'h0000_7000, AW'(200), LW'(4), 0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
